comparator_serial: RTL and testbench

Sequential, parametrised successor to the combinational magnitude comparator. It compares two N-bit operands STEP bits per cycle, MSB slice first, with signed or unsigned mode selectable per transaction. Valid/ready handshakes on both sides let it sit directly between pipeline stages in wide datapaths, where a flat N-bit compare would limit clock rate. It produces the same six relational flags as the combinational comparator, registered and held until consumed.

---
 rtl/comparator_serial.sv | 214 +++++++++++++++++++++
 tb/tb_comparator_serial.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial.sv
// Serial magnitude comparator: STEP bits per cycle, MSB slice first, signed or unsigned.
// Define COMPARATOR_SERIAL_EARLY_EXIT_EN to finish on the first differing slice; otherwise latency is always S.
module comparator_serial #(
  parameter int N    = 16,
  parameter int STEP = 4
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_left,
  input  logic [N-1:0] i_right,
  input  logic         i_signed,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_greater,
  output logic         o_equal,
  output logic         o_less,
  output logic         o_greater_equal,
  output logic         o_not_equal,
  output logic         o_less_equal,
  output logic         o_busy
);

  localparam int S  = N / STEP;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  localparam logic [CW-1:0]   CNT_LAST = CW'(S - 1);
  localparam logic [STEP-1:0] MSB_FLIP = STEP'(1) << (STEP - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic          ge_q, ge_d;
  logic          ne_q, ne_d;
  logic          le_q, le_d;

  logic [N-1:0]  left_q, left_d;
  logic [N-1:0]  right_q, right_d;
  logic          signed_q, signed_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
  // First differing slice's verdict, held while the remaining slices drain.
  logic          dec_q, dec_d;
  logic          dec_gt_q, dec_gt_d;
`endif

  logic            first_slice;
  logic [STEP-1:0] slice_l;
  logic [STEP-1:0] slice_r;
  logic            slice_gt;
  logic            slice_lt;
  logic            slice_ne;
  logic            fin;
  logic            fin_gt;
  logic            fin_lt;
  logic            shift_en;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign first_slice = (cnt_q == CNT_LAST);
  assign slice_l     = left_q[N-1 -: STEP]  ^ ((first_slice && signed_q) ? MSB_FLIP : '0);
  assign slice_r     = right_q[N-1 -: STEP] ^ ((first_slice && signed_q) ? MSB_FLIP : '0);
  assign slice_gt    = (slice_l > slice_r);
  assign slice_lt    = (slice_l < slice_r);
  assign slice_ne    = slice_gt | slice_lt;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ge_d     = ge_q;
    ne_d     = ne_q;
    le_d     = le_q;
    left_d   = left_q;
    right_d  = right_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
    dec_d    = dec_q;
    dec_gt_d = dec_gt_q;
`endif
    fin      = 1'b0;
    fin_gt   = 1'b0;
    fin_lt   = 1'b0;
    shift_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          left_d   = i_left;
          right_d  = i_right;
          signed_d = i_signed;
          cnt_d    = CNT_LAST;
`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
          dec_d    = 1'b0;
`endif
          state_d  = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
        if (slice_ne) begin
          fin    = 1'b1;
          fin_gt = slice_gt;
          fin_lt = slice_lt;
        end else if (cnt_q == '0) begin
          fin = 1'b1;
        end else begin
          shift_en = 1'b1;
        end
`else
        if (!dec_q && slice_ne) begin
          dec_d    = 1'b1;
          dec_gt_d = slice_gt;
        end
        if (cnt_q == '0) begin
          fin = 1'b1;
          if (dec_q) begin
            fin_gt = dec_gt_q;
            fin_lt = !dec_gt_q;
          end else begin
            fin_gt = slice_gt;
            fin_lt = slice_lt;
          end
        end else begin
          shift_en = 1'b1;
        end
`endif
      end

      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (shift_en) begin
      left_d  = left_q << STEP;
      right_d = right_q << STEP;
      cnt_d   = cnt_q - CW'(1);
    end

    if (fin) begin
      state_d = ST_DONE;
      valid_d = 1'b1;
      gt_d    = fin_gt;
      lt_d    = fin_lt;
      eq_d    = !(fin_gt | fin_lt);
      ge_d    = !fin_lt;
      ne_d    = fin_gt | fin_lt;
      le_d    = !fin_gt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      ge_q    <= 1'b0;
      ne_q    <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      ge_q    <= ge_d;
      ne_q    <= ne_d;
      le_q    <= le_d;
    end
  end

  // NOTE: operand datapath is loaded on every accept before use, so it carries no reset.
  always_ff @(posedge i_clock) begin
    left_q   <= left_d;
    right_q  <= right_d;
    signed_q <= signed_d;
    cnt_q    <= cnt_d;
`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
    dec_q    <= dec_d;
    dec_gt_q <= dec_gt_d;
`endif
  end

  assign o_ready         = (state_q == ST_IDLE);
  assign o_busy          = (state_q == ST_COMPARE);
  assign o_valid         = valid_q;
  assign o_greater       = gt_q;
  assign o_equal         = eq_q;
  assign o_less          = lt_q;
  assign o_greater_equal = ge_q;
  assign o_not_equal     = ne_q;
  assign o_less_equal    = le_q;

endmodule

// File: tb/tb_comparator_serial.sv
// Self-checking bench for comparator_serial: directed cases, randomized compares against
// an arithmetic reference, backpressure, back-to-back handoff and mid-transaction reset.
module tb_comparator_serial;

  localparam int N    = 16;
  localparam int STEP = 4;
  localparam int S    = N / STEP;

  logic         clk;
  logic         i_reset_n;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_left;
  logic [N-1:0] i_right;
  logic         i_signed;
  logic         o_valid;
  logic         i_ready;
  logic         o_greater, o_equal, o_less;
  logic         o_greater_equal, o_not_equal, o_less_equal;
  logic         o_busy;

  int checks = 0;
  int errors = 0;

  comparator_serial #(.N(N), .STEP(STEP)) dut (
    .i_clock         (clk),
    .i_reset_n       (i_reset_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_left          (i_left),
    .i_right         (i_right),
    .i_signed        (i_signed),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_greater       (o_greater),
    .o_equal         (o_equal),
    .o_less          (o_less),
    .o_greater_equal (o_greater_equal),
    .o_not_equal     (o_not_equal),
    .o_less_equal    (o_less_equal),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag vector order: {greater, equal, less, greater_equal, not_equal, less_equal}
  function automatic logic [5:0] flags_now();
    return {o_greater, o_equal, o_less, o_greater_equal, o_not_equal, o_less_equal};
  endfunction

  // Reference: relational results straight from integer arithmetic.
  function automatic logic [5:0] ref_flags(input logic [N-1:0] l, input logic [N-1:0] r, input logic s);
    logic gt, eq, lt, ge, ne, le;
    if (s) begin
      gt = $signed(l) >  $signed(r);
      lt = $signed(l) <  $signed(r);
      ge = $signed(l) >= $signed(r);
      le = $signed(l) <= $signed(r);
    end else begin
      gt = l >  r;
      lt = l <  r;
      ge = l >= r;
      le = l <= r;
    end
    eq = (l == r);
    ne = (l != r);
    return {gt, eq, lt, ge, ne, le};
  endfunction

  // Reference latency: 1-based index of the first slice where the operand bits differ.
  function automatic int ref_latency(input logic [N-1:0] l, input logic [N-1:0] r);
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    logic [N-1:0] d;
    d = l ^ r;
    for (int b = N - 1; b >= 0; b--) begin
      if (d[b]) return S - (b / STEP);
    end
    return S;
`else
    return S;
`endif
  endfunction

  // Drives one accept and waits (bounded) for o_valid; lat = -1 on timeout.
  task automatic do_txn(input logic [N-1:0] l, input logic [N-1:0] r, input logic s,
                        output int lat, output logic [5:0] fl, output logic busy_seen);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    i_valid  = 1'b1;
    i_left   = l;
    i_right  = r;
    i_signed = s;
    @(posedge clk);
    #1;
    i_valid   = 1'b0;
    i_left    = N'($urandom);
    i_right   = N'($urandom);
    i_signed  = 1'($urandom);
    busy_seen = o_busy && !o_ready;
    lat = -1;
    for (int k = 1; k <= S + 3; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
      if (o_valid) begin
        lat = k;
        break;
      end
    end
    fl = flags_now();
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_left    = '0;
    i_right   = '0;
    i_signed  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_busy, flags_now()} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b flags=%b, expected all 0", o_valid, o_busy, flags_now());
    end
    i_reset_n = 1'b1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, expected 1", o_ready);
    end
  endtask

  typedef struct {
    logic [N-1:0] l;
    logic [N-1:0] r;
    logic         s;
    logic [5:0]   fl;
    int           lat_early;
  } dir_t;

  task automatic test_directed();
    dir_t cases[4];
    int lat, exp_lat;
    logic [5:0] fl;
    logic busy;
    cases[0] = '{16'h1234, 16'h1234, 1'b0, 6'b010101, 4};
    cases[1] = '{16'h8000, 16'h7FFF, 1'b0, 6'b100110, 1};
    cases[2] = '{16'h8000, 16'h7FFF, 1'b1, 6'b001011, 1};
    cases[3] = '{16'h00F1, 16'h00F2, 1'b0, 6'b001011, 4};
    for (int i = 0; i < 4; i++) begin
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
      exp_lat = cases[i].lat_early;
`else
      exp_lat = S;
`endif
      do_txn(cases[i].l, cases[i].r, cases[i].s, lat, fl, busy);
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d, expected %0d", i, lat, exp_lat);
      end
      checks++;
      if (fl !== cases[i].fl) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got %b, expected %b", i, fl, cases[i].fl);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL directed_busy[%0d]: got busy&!ready=%b, expected 1", i, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] l, r;
    logic s;
    int lat;
    logic [5:0] fl;
    logic busy;
    for (int i = 0; i < 40; i++) begin
      l = N'($urandom);
      case ($urandom_range(0, 2))
        0:       r = l;
        1:       r = l ^ (N'(1) << $urandom_range(0, N - 1));
        default: r = N'($urandom);
      endcase
      s = 1'($urandom);
      do_txn(l, r, s, lat, fl, busy);
      checks++;
      if (lat != ref_latency(l, r)) begin
        errors++;
        $display("FAIL random_latency[%0d] %h vs %h s=%b: got %0d, expected %0d", i, l, r, s, lat, ref_latency(l, r));
      end
      checks++;
      if (fl !== ref_flags(l, r, s)) begin
        errors++;
        $display("FAIL random_flags[%0d] %h vs %h s=%b: got %b, expected %b", i, l, r, s, fl, ref_flags(l, r, s));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] l, r;
    int lat;
    logic [5:0] fl;
    logic busy;
    for (int i = 0; i < 4; i++) begin
      l = N'($urandom);
      r = N'($urandom);
      do_txn(l, r, 1'b1, lat, fl, busy);
      checks++;
      if (o_ready !== 1'b0 || fl !== ref_flags(l, r, 1'b1)) begin
        errors++;
        $display("FAIL b2b_done[%0d]: got ready=%b flags=%b, expected ready=0 flags=%b", i, o_ready, fl, ref_flags(l, r, 1'b1));
      end
      @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_handoff[%0d]: got valid=%b ready=%b, expected valid=0 ready=1", i, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [5:0] fl, exp_fl;
    logic busy;
    exp_fl  = ref_flags(16'h0F00, 16'h0E00, 1'b0);
    i_ready = 1'b0;
    do_txn(16'h0F00, 16'h0E00, 1'b0, lat, fl, busy);
    checks++;
    if (fl !== exp_fl) begin
      errors++;
      $display("FAIL bp_flags: got %b, expected %b", fl, exp_fl);
    end
    for (int c = 0; c < 3; c++) begin
      i_valid  = (c == 0);
      i_left   = 16'h0001;
      i_right  = 16'hFFFF;
      i_signed = 1'b0;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b0 || flags_now() !== exp_fl) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b busy=%b flags=%b, expected 1 0 0 %b",
                 c, o_valid, o_ready, o_busy, flags_now(), exp_fl);
      end
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || flags_now() !== exp_fl) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ready=%b busy=%b flags=%b, expected 0 1 0 %b",
               o_valid, o_ready, o_busy, flags_now(), exp_fl);
    end
  endtask

  task automatic test_reset_mid();
    int lat, n;
    logic [5:0] fl;
    logic busy, saw_valid;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    i_valid  = 1'b1;
    i_left   = 16'h00F1;
    i_right  = 16'h00F2;
    i_signed = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    i_reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_busy, flags_now()} !== 8'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b busy=%b flags=%b, expected all 0", o_valid, o_busy, flags_now());
    end
    i_reset_n = 1'b1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b, expected 1", o_ready);
    end
    saw_valid = 1'b0;
    repeat (S + 2) begin
      @(posedge clk);
      #1;
      saw_valid |= o_valid;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_result: got o_valid seen=%b, expected 0", saw_valid);
    end
    do_txn(16'hFFFE, 16'h0003, 1'b1, lat, fl, busy);
    checks++;
    if (fl !== ref_flags(16'hFFFE, 16'h0003, 1'b1) || lat != ref_latency(16'hFFFE, 16'h0003)) begin
      errors++;
      $display("FAIL midreset_next: got flags=%b lat=%0d, expected flags=%b lat=%0d",
               fl, lat, ref_flags(16'hFFFE, 16'h0003, 1'b1), ref_latency(16'hFFFE, 16'h0003));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
